fc8_audio_synth: RTL and testbench
==================================

FC8_AUDIO_SYNTH -- requirements
Module: fc8_audio_synth

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of tone channels (1..8).
REQ-002 SHALL have parameter ACC_W, default 16, phase-accumulator and frequency-word width (12..24).
REQ-003 SHALL have parameter PWM_W, default 8, PWM resolution and sample width (6..10).
REQ-004 SHALL have port audio_clk, input, 1, sole clock (1 MHz nominal).
REQ-005 SHALL have port rst_n, input, 1, reset; asynchronous assert, active-low.
REQ-006 SHALL have port vsync_pulse_in, input, 1, one-cycle envelope tick.
REQ-007 SHALL have port ch_freq_in, input, NUM_CH*ACC_W, per-channel phase increment; channel n at [n*ACC_W +: ACC_W].
REQ-008 SHALL have port ch_vol_env_in, input, NUM_CH*8, per channel: [7:4] start volume, [3] envelope enable, [2:0] envelope period.
REQ-009 SHALL have port ch_wave_duty_in, input, NUM_CH*8, per channel: [7:6] waveform, [5:4] duty.
REQ-010 SHALL have port ch_ctrl_in, input, NUM_CH*8, per channel: [0] enable, [1] envelope loop.
REQ-011 SHALL have port master_vol_in, input, 8, [2:0] master volume.
REQ-012 SHALL have port audio_sys_enable_in, input, 8, [0] global enable.
REQ-013 SHALL have port sample_out, output, PWM_W, sample currently driving PWM.
REQ-014 SHALL have port sample_valid_out, output, 1, one-cycle pulse when sample_out updates.
REQ-015 SHALL have port audio_pwm_out, output, 1, PWM audio.

Function
REQ-016 SHALL add freq to a channel's accumulator each cycle while ctrl[0]=1 (modulo 2^ACC_W); ctrl[0]=0 forces accumulator, output and envelope to 0.
REQ-017 SHALL form 4-bit wave W from accumulator top bits T=acc[ACC_W-1 -: 3]: waveform 00 square, W=15 when T < {1,2,4,6}[duty] else 0; 01 sawtooth, W=acc top nibble; 10 triangle, W=top-nibble-after-MSB, inverted when MSB=1; 11 noise (REQ-029).
REQ-018 SHALL register channel output = W*V (8 bits, max 225), V = effective volume.
REQ-019 SHALL, on ctrl[0] 0->1 (key-on), load V=vol_env[7:4] and envelope counter=period.
REQ-020 SHALL, with vol_env[3]=0, track V = vol_env[7:4] continuously.
REQ-021 SHALL, with vol_env[3]=1, on each vsync_pulse_in decrement envelope counter; at 0 reload period and decrement V; V=0 holds 0, or reloads 15 if ctrl[1]=1; period 0 means step every tick.
REQ-022 SHALL register the sum of all channel outputs, width MW = 8+clog2(NUM_CH), no overflow possible.
REQ-023 SHALL register scaled = (sum*(master+1))>>3, then final = scaled[MW-1 -: PWM_W] (zero-extended LSBs if MW<PWM_W).
REQ-024 SHALL force final=0 while audio_sys_enable_in[0]=0.
REQ-025 SHALL free-run a PWM_W-bit counter; audio_pwm_out registered = (counter < sample_out).
REQ-026 SHALL load sample_out from final only on the cycle counter = all-ones, pulsing sample_valid_out that cycle; mid-period changes never glitch the PWM.
REQ-027 SHALL give 3 cycles latency accumulator update -> final (channel, mix, master stages).
REQ-028 SHALL process simultaneous key-on and vsync tick as key-on only.

Reset
REQ-029 SHALL on rst_n=0 clear all accumulators, volumes, envelope counters, pipeline registers, PWM counter, sample_out, sample_valid_out, audio_pwm_out to 0 and LFSRs to 15'h0001, immediately; mid-note reset restarts at key-on only after a fresh 0->1 of ctrl[0].

Configuration
REQ-030 SHALL, with FC8_AUDIO_NOISE_EN defined, give each channel a 15-bit LFSR (x^15+x^14+1) stepped on every accumulator carry-out; waveform 11 gives W=15 when LFSR[0]=1 else 0.
REQ-031 SHALL, without FC8_AUDIO_NOISE_EN, omit LFSRs; waveform 11 behaves as square 50% duty.

Verification
REQ-032 Reset: rst_n low mid-note -> all outputs 0 same cycle; LFSR=15'h0001 after release.
REQ-033 Square: NUM_CH=4, ch0 freq=16'h0100, duty=2, vol=15, master=7, others off -> period 256 clks, high 128, final=225>>2=56, sample_out=56 at next PWM wrap; PWM high 56 of 256.
REQ-034 Envelope: vol=4, env en, period=1, loop=0 -> V 4,3,2,1,0 every 2 vsync ticks, then holds 0; with loop=1 -> 15 after 0.
REQ-035 Mix saturation-free: all 4 channels square vol 15 in phase, master=7 -> sum=900, final=225.
REQ-036 Master/enable: master=3 halves final (28 for REQ-033 case); audio_sys_enable_in[0]=0 -> sample_out 0 at next wrap, audio_pwm_out stays 0.
REQ-037 Noise: FC8_AUDIO_NOISE_EN defined, freq=16'h8000 -> LFSR steps every 2 clks, sequence from 15'h0001 matches reference model over 32767 steps.

Source files
------------

// File: rtl/fc8_audio_synth.sv
// rtl/fc8_audio_synth.sv - multi-channel tone synth: phase accumulators, envelopes, mixer, master scale, PWM out
// Define FC8_AUDIO_NOISE_EN to give each channel a 15-bit noise LFSR for waveform 11.
module fc8_audio_synth #(
  parameter int NUM_CH = 4,
  parameter int ACC_W  = 16,
  parameter int PWM_W  = 8
) (
  input  logic                      audio_clk,
  input  logic                      rst_n,
  input  logic                      vsync_pulse_in,
  input  logic [NUM_CH*ACC_W-1:0]   ch_freq_in,
  input  logic [NUM_CH*8-1:0]       ch_vol_env_in,
  input  logic [NUM_CH*8-1:0]       ch_wave_duty_in,
  input  logic [NUM_CH*8-1:0]       ch_ctrl_in,
  input  logic [7:0]                master_vol_in,
  input  logic [7:0]                audio_sys_enable_in,
  output logic [PWM_W-1:0]          sample_out,
  output logic                      sample_valid_out,
  output logic                      audio_pwm_out
);

  localparam int MW = 8 + $clog2(NUM_CH);

  logic [NUM_CH-1:0][ACC_W-1:0] acc_q, acc_d;
  logic [NUM_CH-1:0][ACC_W:0]   acc_sum;
  logic [NUM_CH-1:0][3:0]       vol_q, vol_d, veff, wave_w;
  logic [NUM_CH-1:0][2:0]       env_cnt_q, env_cnt_d;
  logic [NUM_CH-1:0][7:0]       chan_q, chan_d;
  logic [NUM_CH-1:0]            en_prev_q, en_prev_d, gate_q, gate_d, keyon, run;
  logic [MW-1:0]                sum_q, sum_d;
  logic [3:0]                   master_mul;
  logic [MW+3:0]                prod;
  logic [MW-1:0]                scaled;
  logic [PWM_W-1:0]             final_trunc, final_q, final_d;
  logic [PWM_W-1:0]             pwm_cnt_q, pwm_cnt_d, sample_q, sample_d;
  logic                         valid_q, valid_d, pwm_q, pwm_d;
  logic                         unused_bits;
`ifdef FC8_AUDIO_NOISE_EN
  logic [NUM_CH-1:0][14:0]      lfsr_q, lfsr_d;
`endif

  function automatic logic [2:0] sq_thr(input logic [1:0] duty);
    case (duty)
      2'd0:    sq_thr = 3'd1;
      2'd1:    sq_thr = 3'd2;
      2'd2:    sq_thr = 3'd4;
      default: sq_thr = 3'd6;
    endcase
  endfunction

  // A channel only runs after a genuine 0->1 edge of its enable; en_prev resets high so
  // an enable held across reset does not count as a key-on.
  always_comb begin
    for (int n = 0; n < NUM_CH; n++) begin
      keyon[n]     = ch_ctrl_in[n*8] & ~en_prev_q[n];
      run[n]       = ch_ctrl_in[n*8] & (gate_q[n] | keyon[n]);
      en_prev_d[n] = ch_ctrl_in[n*8];
      gate_d[n]    = run[n];
      acc_sum[n]   = {1'b0, acc_q[n]} + {1'b0, ch_freq_in[n*ACC_W +: ACC_W]};
      acc_d[n]     = run[n] ? acc_sum[n][ACC_W-1:0] : '0;

      vol_d[n]     = vol_q[n];
      env_cnt_d[n] = env_cnt_q[n];
      if (!run[n]) begin
        vol_d[n]     = 4'd0;
        env_cnt_d[n] = 3'd0;
      end else if (keyon[n]) begin
        vol_d[n]     = ch_vol_env_in[n*8+4 +: 4];
        env_cnt_d[n] = ch_vol_env_in[n*8 +: 3];
      end else if (!ch_vol_env_in[n*8+3]) begin
        vol_d[n]     = ch_vol_env_in[n*8+4 +: 4];
      end else if (vsync_pulse_in) begin
        if (env_cnt_q[n] == 3'd0) begin
          env_cnt_d[n] = ch_vol_env_in[n*8 +: 3];
          if (vol_q[n] != 4'd0)      vol_d[n] = vol_q[n] - 4'd1;
          else if (ch_ctrl_in[n*8+1]) vol_d[n] = 4'd15;
          else                        vol_d[n] = 4'd0;
        end else begin
          env_cnt_d[n] = env_cnt_q[n] - 3'd1;
        end
      end
      veff[n] = ch_vol_env_in[n*8+3] ? vol_q[n] : ch_vol_env_in[n*8+4 +: 4];

      case (ch_wave_duty_in[n*8+6 +: 2])
        2'b00:   wave_w[n] = (acc_q[n][ACC_W-1 -: 3] < sq_thr(ch_wave_duty_in[n*8+4 +: 2])) ? 4'hF : 4'h0;
        2'b01:   wave_w[n] = acc_q[n][ACC_W-1 -: 4];
        2'b10:   wave_w[n] = acc_q[n][ACC_W-1] ? ~acc_q[n][ACC_W-2 -: 4] : acc_q[n][ACC_W-2 -: 4];
`ifdef FC8_AUDIO_NOISE_EN
        default: wave_w[n] = lfsr_q[n][0] ? 4'hF : 4'h0;
`else
        default: wave_w[n] = (acc_q[n][ACC_W-1 -: 3] < sq_thr(2'd2)) ? 4'hF : 4'h0;
`endif
      endcase
      chan_d[n] = run[n] ? ({4'd0, wave_w[n]} * {4'd0, veff[n]}) : 8'd0;

`ifdef FC8_AUDIO_NOISE_EN
      lfsr_d[n] = (run[n] & acc_sum[n][ACC_W]) ? {lfsr_q[n][13:0], lfsr_q[n][14] ^ lfsr_q[n][13]}
                                               : lfsr_q[n];
`endif
    end
  end

  always_comb begin
    sum_d = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      sum_d = sum_d + MW'(chan_q[n]);
    end
  end

  // sum*8>>3 is the largest product, so the shifted result always fits in MW bits.
  assign master_mul = {1'b0, master_vol_in[2:0]} + 4'd1;
  assign prod       = (MW+4)'(sum_q) * (MW+4)'(master_mul);
  assign scaled     = prod[MW+2:3];

  generate
    if (MW >= PWM_W) begin : g_trunc
      assign final_trunc = scaled[MW-1 -: PWM_W];
    end else begin : g_pad
      assign final_trunc = {scaled, {(PWM_W-MW){1'b0}}};
    end
  endgenerate

  // sample_q only changes at counter wrap, so a PWM period always uses one level.
  always_comb begin
    final_d   = audio_sys_enable_in[0] ? final_trunc : '0;
    pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
    valid_d   = &pwm_cnt_q;
    sample_d  = valid_d ? final_q : sample_q;
    pwm_d     = pwm_cnt_q < sample_q;
  end

  always_ff @(posedge audio_clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      vol_q     <= '0;
      env_cnt_q <= '0;
      chan_q    <= '0;
      en_prev_q <= '1;
      gate_q    <= '0;
      sum_q     <= '0;
      final_q   <= '0;
      pwm_cnt_q <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      pwm_q     <= 1'b0;
`ifdef FC8_AUDIO_NOISE_EN
      lfsr_q    <= {NUM_CH{15'h0001}};
`endif
    end else begin
      acc_q     <= acc_d;
      vol_q     <= vol_d;
      env_cnt_q <= env_cnt_d;
      chan_q    <= chan_d;
      en_prev_q <= en_prev_d;
      gate_q    <= gate_d;
      sum_q     <= sum_d;
      final_q   <= final_d;
      pwm_cnt_q <= pwm_cnt_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      pwm_q     <= pwm_d;
`ifdef FC8_AUDIO_NOISE_EN
      lfsr_q    <= lfsr_d;
`endif
    end
  end

  assign sample_out       = sample_q;
  assign sample_valid_out = valid_q;
  assign audio_pwm_out    = pwm_q;

  assign unused_bits = ^{ch_ctrl_in, ch_wave_duty_in, master_vol_in, audio_sys_enable_in,
                         prod, scaled, acc_sum};

endmodule

// File: tb/tb_fc8_audio_synth.sv
// tb/tb_fc8_audio_synth.sv - directed self-checking bench for fc8_audio_synth
module tb_fc8_audio_synth;
  localparam int NUM_CH = 4;
  localparam int ACC_W  = 16;
  localparam int PWM_W  = 8;

  localparam logic [7:0] SQ50  = 8'h20;
  localparam logic [7:0] SAW   = 8'h40;
  localparam logic [7:0] TRI   = 8'h80;

  logic                    audio_clk = 1'b0;
  logic                    rst_n;
  logic                    vsync;
  logic [NUM_CH*ACC_W-1:0] freq;
  logic [NUM_CH*8-1:0]     vol_env, wave_duty, ctrl;
  logic [7:0]              master, sys_en;
  logic [PWM_W-1:0]        sample_out;
  logic                    sample_valid_out, audio_pwm_out;

  int errors = 0;
  int checks = 0;
  int hi;

  fc8_audio_synth #(.NUM_CH(NUM_CH), .ACC_W(ACC_W), .PWM_W(PWM_W)) dut (
    .audio_clk           (audio_clk),
    .rst_n               (rst_n),
    .vsync_pulse_in      (vsync),
    .ch_freq_in          (freq),
    .ch_vol_env_in       (vol_env),
    .ch_wave_duty_in     (wave_duty),
    .ch_ctrl_in          (ctrl),
    .master_vol_in       (master),
    .audio_sys_enable_in (sys_en),
    .sample_out          (sample_out),
    .sample_valid_out    (sample_valid_out),
    .audio_pwm_out       (audio_pwm_out)
  );

  always #5 audio_clk = ~audio_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    int   n    = 0;
    logic seen = 1'b0;
    while (!seen && n < 600) begin
      @(negedge audio_clk);
      n++;
      seen = sample_valid_out;
    end
    check({tag, "_valid"}, {31'd0, seen}, 32'd1);
  endtask

  task automatic settle(input string tag, input int exp);
    wait_valid(tag);
    wait_valid(tag);
    check(tag, {24'd0, sample_out}, exp);
  endtask

  task automatic count_pwm(output int high);
    high = 0;
    repeat (256) begin
      @(negedge audio_clk);
      high += int'(audio_pwm_out);
    end
  endtask

  task automatic tick();
    @(negedge audio_clk);
    vsync = 1'b1;
    @(negedge audio_clk);
    vsync = 1'b0;
  endtask

  task automatic set_ch(input int n, input logic [15:0] f, input logic [7:0] ve, input logic [7:0] wd);
    freq[n*ACC_W +: ACC_W] = f;
    vol_env[n*8 +: 8]      = ve;
    wave_duty[n*8 +: 8]    = wd;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; vsync = 1'b0; freq = '0; vol_env = '0; wave_duty = '0; ctrl = '0;
    master = 8'd7; sys_en = 8'd1;
    repeat (3) @(negedge audio_clk);
    check("reset_sample", {24'd0, sample_out}, 0);
    check("reset_valid", {31'd0, sample_valid_out}, 0);
    check("reset_pwm", {31'd0, audio_pwm_out}, 0);
    rst_n = 1'b1;

    // Square 50%: keyed on 200 cycles after a wrap so the next wrap samples the high half
    set_ch(0, 16'h0100, 8'hF0, SQ50);
    wait_valid("sq_sync");
    repeat (200) @(negedge audio_clk);
    ctrl[0] = 1'b1;
    wait_valid("sq");
    check("sq_sample", {24'd0, sample_out}, 56);
    count_pwm(hi);
    check("sq_pwm_high", hi, 56);
    check("sq_valid_wrap2", {31'd0, sample_valid_out}, 1);
    check("sq_sample_wrap2", {24'd0, sample_out}, 56);

    master = 8'd3;
    wait_valid("master3");
    check("master3", {24'd0, sample_out}, 28);
    master = 8'd7;

    sys_en = 8'd0;
    wait_valid("disable");
    check("disable_sample", {24'd0, sample_out}, 0);
    count_pwm(hi);
    check("disable_pwm_high", hi, 0);
    sys_en = 8'd1;

    wave_duty[7:0] = 8'h00;
    wait_valid("duty0");
    check("duty0", {24'd0, sample_out}, 0);
    wave_duty[7:0] = 8'h30;
    wait_valid("duty3");
    check("duty3", {24'd0, sample_out}, 56);
`ifndef FC8_AUDIO_NOISE_EN
    wave_duty[7:0] = 8'hC0;
    wait_valid("noise_as_sq");
    check("noise_as_sq", {24'd0, sample_out}, 56);
`endif
    ctrl = '0;

    for (int n = 0; n < NUM_CH; n++) set_ch(n, 16'h0100, 8'hF0, SQ50);
    wait_valid("mix_sync");
    repeat (200) @(negedge audio_clk);
    ctrl = 32'h0101_0101;
    wait_valid("mix");
    check("mix_sample", {24'd0, sample_out}, 225);
    count_pwm(hi);
    check("mix_pwm_high", hi, 225);
    ctrl = '0;
    for (int n = 1; n < NUM_CH; n++) set_ch(n, 16'h0000, 8'h00, 8'h00);

    // Period-4 accumulator: key-on delay picks which phase lands on the wrap
    set_ch(0, 16'hC000, 8'hF0, SAW);
    wait_valid("saw_sync");
    repeat (199) @(negedge audio_clk);
    ctrl[0] = 1'b1;
    wait_valid("saw");
    check("saw_c000", {24'd0, sample_out}, 45);

    ctrl[0] = 1'b0;
    wave_duty[7:0] = TRI;
    wait_valid("tri_sync");
    repeat (198) @(negedge audio_clk);
    ctrl[0] = 1'b1;
    wait_valid("tri");
    check("tri_8000", {24'd0, sample_out}, 56);

    ctrl[0] = 1'b0;
    wait_valid("tri_sync2");
    repeat (201) @(negedge audio_clk);
    ctrl[0] = 1'b1;
    wait_valid("tri2");
    check("tri_4000", {24'd0, sample_out}, 30);

    ctrl[0] = 1'b0;
    wait_valid("tri_sync3");
    repeat (199) @(negedge audio_clk);
    ctrl[0] = 1'b1;
    wait_valid("tri3");
    check("tri_c000", {24'd0, sample_out}, 26);

    // Envelope: start 4, period 1 -> one step per two ticks
    ctrl = '0;
    set_ch(0, 16'h0000, 8'h49, SQ50);
    @(negedge audio_clk);
    ctrl[0] = 1'b1;
    settle("env_v4", 15);
    tick(); tick();
    settle("env_v3", 11);
    tick(); tick();
    settle("env_v2", 7);
    tick(); tick();
    settle("env_v1", 3);
    tick(); tick();
    settle("env_v0", 0);
    tick(); tick();
    settle("env_hold0", 0);
    ctrl[1] = 1'b1;
    tick(); tick();
    settle("env_loop15", 56);

    ctrl = '0;
    vol_env[7:0] = 8'h48;
    @(negedge audio_clk);
    ctrl[0] = 1'b1;
    vsync   = 1'b1;
    @(negedge audio_clk);
    vsync   = 1'b0;
    settle("keyon_tick", 15);
    tick();
    settle("period0_step", 11);

    ctrl = '0;
    vol_env[7:0] = 8'hF0;
    @(negedge audio_clk);
    ctrl[0] = 1'b1;
    settle("pre_reset", 56);
    @(posedge audio_clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_sample", {24'd0, sample_out}, 0);
    check("midreset_valid", {31'd0, sample_valid_out}, 0);
    check("midreset_pwm", {31'd0, audio_pwm_out}, 0);
    @(negedge audio_clk);
    rst_n = 1'b1;
    settle("no_restart", 0);
    ctrl[0] = 1'b0;
    @(negedge audio_clk);
    ctrl[0] = 1'b1;
    settle("rekey", 56);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
